// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types, default parameters and saturating add for the GEMM engine
package systolic_pkg;

  localparam int DEF_N      = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 16;
  localparam int DEF_SAT_EN = 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_COMPUTE = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  // Adds two sign-extended values and clamps the sum to a signed i_w-bit range.
  // o_ovf reports that the exact sum did not fit, which also means a wrap in modulo mode.
  function automatic logic signed [63:0] sat_add(
    input  logic signed [63:0] i_x,
    input  logic signed [63:0] i_y,
    input  int                 i_w,
    output logic               o_ovf
  );
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] res;
    sum   = i_x + i_y;
    hi    = (64'sd1 <<< (i_w - 1)) - 64'sd1;
    lo    = -(64'sd1 <<< (i_w - 1));
    o_ovf = 1'b0;
    res   = sum;
    if (sum > hi) begin
      o_ovf = 1'b1;
      res   = hi;
    end else if (sum < lo) begin
      o_ovf = 1'b1;
      res   = lo;
    end
    return res;
  endfunction

endpackage

// File: rtl/systolic_gemm_engine_if.sv
// rtl/systolic_gemm_engine_if.sv - control, load and result handshake bundle of the GEMM engine
interface systolic_gemm_engine_if
  import systolic_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) ();

  logic                  start;
  logic                  acc_mode;
  logic                  busy;
  logic                  done;
  logic                  ld_valid;
  logic                  ld_ready;
  logic [N*DATA_W-1:0]   ld_a_col;
  logic [N*DATA_W-1:0]   ld_b_row;
  logic                  c_valid;
  logic                  c_ready;
  logic [N*ACC_W-1:0]    c_row;
  logic                  ovf;

  modport master (
    output start, acc_mode, ld_valid, ld_a_col, ld_b_row, c_ready,
    input  busy, done, ld_ready, c_valid, c_row, ovf
  );

  modport slave (
    input  start, acc_mode, ld_valid, ld_a_col, ld_b_row, c_ready,
    output busy, done, ld_ready, c_valid, c_row, ovf
  );

endinterface

// File: rtl/systolic_pe.sv
// rtl/systolic_pe.sv - one processing element: forwards A right and B down, accumulates a*b
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int SAT_EN = DEF_SAT_EN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_en,
  input  logic                     i_clr,
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  output logic signed [DATA_W-1:0] o_a,
  output logic signed [DATA_W-1:0] o_b,
  output logic signed [ACC_W-1:0]  o_acc,
  output logic                     o_ovf
);

  logic signed [DATA_W-1:0]   r_a;
  logic signed [DATA_W-1:0]   r_b;
  logic signed [ACC_W-1:0]    r_acc;
  logic                       r_ovf;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [63:0]         w_acc_ext;
  logic signed [63:0]         w_prod_ext;
  logic signed [63:0]         w_sat;
  logic signed [63:0]         w_wrap;
  logic                       w_range_ovf;
  logic signed [ACC_W-1:0]    w_next;
  logic                       w_unused_hi;

  assign w_prod     = i_a * i_b;
  assign w_acc_ext  = {{(64-ACC_W){r_acc[ACC_W-1]}}, r_acc};
  assign w_prod_ext = {{(64-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
  assign w_unused_hi = ^{w_sat[63:ACC_W], w_wrap[63:ACC_W]};

  // Full-precision sum, then either clamp or keep the low ACC_W bits
  always_comb begin
    w_sat  = sat_add(w_acc_ext, w_prod_ext, ACC_W, w_range_ovf);
    w_wrap = w_acc_ext + w_prod_ext;
    w_next = (SAT_EN != 0) ? w_sat[ACC_W-1:0] : w_wrap[ACC_W-1:0];
  end

  // Operand forwarding registers and the accumulator with its sticky overflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_a <= i_a;
      r_b <= i_b;
      if (i_clr) begin
        r_acc <= '0;
        r_ovf <= 1'b0;
      end else if (i_en) begin
        r_acc <= w_next;
        if (w_range_ovf) r_ovf <= 1'b1;
      end
    end
  end

  assign o_a   = r_a;
  assign o_b   = r_b;
  assign o_acc = r_acc;
  assign o_ovf = r_ovf;

endmodule

// File: rtl/systolic_gemm_engine.sv
// rtl/systolic_gemm_engine.sv - NxN output-stationary systolic GEMM with load buffers, skew feeder and row drain
module systolic_gemm_engine
  import systolic_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int SAT_EN = DEF_SAT_EN
) (
  input  logic                 clk,
  input  logic                 rst,
  systolic_gemm_engine_if.slave bus
);

  // One counter serves as beat index in LOAD, skew time t in COMPUTE and row index in DRAIN
  localparam int CNT_W = $clog2(3*N) + 1;

  state_t                   r_state;
  state_t                   w_next_state;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_done;
  logic signed [DATA_W-1:0] r_a_buf [N][N];
  logic signed [DATA_W-1:0] r_b_buf [N][N];

  logic                     w_ld_fire;
  logic                     w_c_fire;
  logic                     w_clr;
  logic                     w_en;
  logic                     w_last_beat;
  logic                     w_compute_end;
  logic                     w_last_row;
  logic signed [DATA_W-1:0] w_feed_a [N];
  logic signed [DATA_W-1:0] w_feed_b [N];
  logic signed [DATA_W-1:0] w_a [N][N+1];
  logic signed [DATA_W-1:0] w_b [N+1][N];
  logic signed [ACC_W-1:0]  w_acc [N][N];
  logic [N*N-1:0]           w_ovf;
  logic                     w_unused_edge;

  assign w_ld_fire     = (r_state == S_LOAD) && bus.ld_valid;
  assign w_c_fire      = (r_state == S_DRAIN) && bus.c_ready;
  assign w_clr         = (r_state == S_IDLE) && bus.start && !bus.acc_mode;
  assign w_en          = (r_state == S_COMPUTE);
  assign w_last_beat   = (r_cnt == CNT_W'(N-1));
  assign w_compute_end = (r_cnt == CNT_W'(3*N-2));
  assign w_last_row    = (r_cnt == CNT_W'(N-1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // Next-state logic; start is only looked at in IDLE
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (bus.start) w_next_state = S_LOAD;
      S_LOAD:    if (w_ld_fire && w_last_beat) w_next_state = S_COMPUTE;
      S_COMPUTE: if (w_compute_end) w_next_state = S_DRAIN;
      S_DRAIN:   if (w_c_fire && w_last_row) w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Shared counter restarts on every state change and steps on accepted beats, compute cycles and accepted rows
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_next_state != r_state) begin
      r_cnt <= '0;
    end else if (w_ld_fire || w_en || w_c_fire) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Done pulses in the first IDLE cycle after the last row is taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_done <= 1'b0;
    else      r_done <= w_c_fire && w_last_row;
  end

  // Beat k carries column k of A and row k of B
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          r_a_buf[i][k] <= '0;
          r_b_buf[k][i] <= '0;
        end
      end
    end else if (w_ld_fire) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (r_cnt == CNT_W'(k)) begin
            r_a_buf[i][k] <= bus.ld_a_col[i*DATA_W +: DATA_W];
            r_b_buf[k][i] <= bus.ld_b_row[i*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  // Skew feeder: row i gets A[i][t-i], column j gets B[t-j][j], zero outside the diagonal band
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_feed_a[i] = '0;
      w_feed_b[i] = '0;
    end
    if (r_state == S_COMPUTE) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (int'(r_cnt) == i + k) begin
            w_feed_a[i] = r_a_buf[i][k];
            w_feed_b[i] = r_b_buf[k][i];
          end
        end
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_edge
    assign w_a[gi][0] = w_feed_a[gi];
    assign w_b[0][gi] = w_feed_b[gi];
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      systolic_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SAT_EN (SAT_EN)
      ) u_pe (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_en),
        .i_clr (w_clr),
        .i_a   (w_a[gi][gj]),
        .i_b   (w_b[gi][gj]),
        .o_a   (w_a[gi][gj+1]),
        .o_b   (w_b[gi+1][gj]),
        .o_acc (w_acc[gi][gj]),
        .o_ovf (w_ovf[gi*N+gj])
      );
    end
  end

  // Operands leaving the far edges of the array have no consumer
  always_comb begin
    w_unused_edge = 1'b0;
    for (int i = 0; i < N; i++) w_unused_edge = w_unused_edge ^ (^{w_a[i][N], w_b[N][i]});
  end

  // Drain mux presents accumulator row r_cnt; held while c_ready is low because r_cnt only moves on accept
  always_comb begin
    bus.c_row = '0;
    if (r_state == S_DRAIN) begin
      for (int r = 0; r < N; r++) begin
        if (r_cnt == CNT_W'(r)) begin
          for (int j = 0; j < N; j++) bus.c_row[j*ACC_W +: ACC_W] = w_acc[r][j];
        end
      end
    end
  end

  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = r_done;
  assign bus.ld_ready = (r_state == S_LOAD);
  assign bus.c_valid  = (r_state == S_DRAIN);
  assign bus.ovf      = |w_ovf;

endmodule

// File: doc/systolic_gemm_engine.md
SYSTOLIC_GEMM_ENGINE -- requirements
Module: systolic_gemm_engine

Interface
REQ-001 SHALL have parameter N, default 4, array dimension (N x N PEs, K = N per pass), N >= 2.
REQ-002 SHALL have parameter DATA_W, default 8, signed two's-complement operand width.
REQ-003 SHALL have parameter ACC_W, default 16, signed accumulator/result width, ACC_W >= 2*DATA_W.
REQ-004 SHALL have parameter SAT_EN, default 1; 1 = saturating accumulate, 0 = wrap-around.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  pulse; begins a pass when idle.
REQ-008 SHALL have port acc_mode  input  1  sampled with start; 1 = keep prior accumulators (K-tiling), 0 = clear.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse at pass completion.
REQ-011 SHALL have port ld_valid  input  1  load beat valid.
REQ-012 SHALL have port ld_ready  output  1  load beat accepted when ld_valid & ld_ready.
REQ-013 SHALL have port ld_a_col  input  N*DATA_W  beat k: A[i][k] in slice i.
REQ-014 SHALL have port ld_b_row  input  N*DATA_W  beat k: B[k][j] in slice j.
REQ-015 SHALL have port c_valid  output  1  result row valid.
REQ-016 SHALL have port c_ready  input  1  result row accepted when c_valid & c_ready.
REQ-017 SHALL have port c_row  output  N*ACC_W  row i of C, slice j = C[i][j].
REQ-018 SHALL have port ovf  output  1  sticky; set when any accumulate saturated/wrapped this pass.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, COMPUTE, DRAIN; exactly one active.
REQ-020 IDLE: start=1 -> LOAD next cycle; acc_mode latched; if acc_mode=0 all accumulators cleared and ovf cleared in same transition.
REQ-021 start SHALL be ignored outside IDLE.
REQ-022 LOAD: ld_ready=1; beat k (0..N-1) written into internal A/B buffers; after N-th accepted beat -> COMPUTE; ld_valid gaps stall without loss.
REQ-023 COMPUTE: internal skew feeder drives row i with A[i][t-i] and column j with B[t-j][j] for 0 <= t-i, t-j < N, else 0, t = 0..3N-3; state lasts exactly 3N-1 cycles, then -> DRAIN.
REQ-024 Each PE SHALL forward A right and B down with one register each and accumulate acc += a*b with sign-extended full-precision product.
REQ-025 SAT_EN=1: sum clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; SAT_EN=0: modulo 2^ACC_W; either case sets ovf.
REQ-026 DRAIN: c_valid=1, c_row = row r, r = 0..N-1; r advances only on c_valid & c_ready; c_row stable while c_ready=0.
REQ-027 After row N-1 accepted -> IDLE and done=1 for exactly that cycle; accumulators retained for next acc_mode=1 pass.
REQ-028 ld_ready=0 outside LOAD; c_valid=0 outside DRAIN.

Reset
REQ-029 rst low SHALL immediately force IDLE, busy=0, done=0, ld_ready=0, c_valid=0, c_row=0, ovf=0, all accumulators, pipeline registers, buffers and counters to 0, including mid-LOAD/COMPUTE/DRAIN.
REQ-030 First start SHALL be honoured on the first rising edge after rst deasserts.

Structure
REQ-031 Shared package systolic_pkg SHALL hold state enum, default parameters and saturating-add function.
REQ-032 One sub-module systolic_pe (registered a/b forward + MAC) SHALL be instantiated N*N via generate; FSM, buffers, skew feeder, drain mux in top.

Verification (N=4, DATA_W=8, ACC_W=16)
REQ-033 A rows all {1,2,3,4}, B rows all {4,3,2,1}, acc_mode=0 -> every c_row = {40,30,20,10}, done one cycle after 4th row accepted, ovf=0.
REQ-034 Same operands, second pass acc_mode=1 -> every c_row = {80,60,40,20}.
REQ-035 A=all 127, B=all 127 (sum 64516), SAT_EN=1 -> all C = 32767, ovf=1; SAT_EN=0 -> all C = -1020, ovf=1.
REQ-036 A=all -128, B=identity -> C = all -128 on diagonal column pattern (C[i][j] = -128), signed path check.
REQ-037 c_ready low 5 cycles during row 1 -> c_row holds row 1, no row skipped; ld_valid toggled every other cycle -> result unchanged.
REQ-038 rst low at COMPUTE cycle 3 -> all outputs 0 next sample, busy=0; new pass of REQ-033 then correct.
